// File: rtl/wash_pkg.sv
// ============================================================================
// Module      : wash_pkg
// Description : Shared state, phase and timing definitions for the wash
//               program sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wash_pkg;

    localparam int TIME_W  = 7;
    localparam int TOTAL_T = 21;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] PH_WASH  = 2'd0;
    localparam logic [1:0] PH_RINSE = 2'd1;
    localparam logic [1:0] PH_SPIN  = 2'd2;
    localparam logic [1:0] PH_NONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/wash_sequencer_if.sv
// ============================================================================
// Module      : wash_sequencer_if
// Description : Control/feedback link between the program sequencer and the
//               countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wash_sequencer_if;
    import wash_pkg::*;

    logic [TIME_W-1:0] rest_time;
    logic              stop;
    logic              dis;
    logic              off_r;
    logic [TIME_W-1:0] next_time;

    modport master (
        output rest_time,
        output stop,
        output dis,
        output off_r,
        input  next_time
    );

    modport slave (
        input  rest_time,
        input  stop,
        input  dis,
        input  off_r,
        output next_time
    );

endinterface

`default_nettype wire

// File: rtl/wash_sequencer_btn_edge.sv
// ============================================================================
// Module      : btn_edge
// Description : Rising-edge detector for a synchronous front-panel level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level;
        end
    end

    assign pulse = level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/wash_sequencer.sv
// ============================================================================
// Module      : wash_sequencer
// Description : WASH -> RINSE -> SPIN program sequencer driving the countdown
//               timer, with power/start/pause handling and end buzzer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned WASH_T   = 9,
    parameter int unsigned RINSE_T  = 6,
    parameter int unsigned SPIN_T   = 6,
    parameter int unsigned BUZZ_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               power_btn,
    input  logic               start_btn,
    input  logic               pause_btn,
    wash_sequencer_if.master   tmr,
    output logic [1:0]         phase,
    output logic               running,
    output logic               buzzer
);

    localparam logic [TIME_W-1:0] c_wash_t    = TIME_W'(WASH_T);
    localparam logic [TIME_W-1:0] c_rinse_t   = TIME_W'(RINSE_T);
    localparam logic [TIME_W-1:0] c_spin_t    = TIME_W'(SPIN_T);
    localparam int                c_buzz_w    = (BUZZ_CYC > 2) ? $clog2(BUZZ_CYC) : 1;
    localparam logic [c_buzz_w-1:0] c_buzz_last = c_buzz_w'(BUZZ_CYC - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [TIME_W-1:0]   r_rest_time;
    logic [1:0]          r_phase;
    logic                r_load_skip;
    logic [c_buzz_w-1:0] r_buzz_cnt;

    logic w_power_edge;
    logic w_start_edge;
    logic w_pause_edge;
    logic w_phase_end;
    logic w_off_r;
    logic w_stop;
    logic w_dis;
    logic w_running;
    logic w_buzzer;

    btn_edge u_power_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (power_btn),
        .pulse (w_power_edge)
    );

    btn_edge u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (start_btn),
        .pulse (w_start_edge)
    );

    btn_edge u_pause_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (pause_btn),
        .pulse (w_pause_edge)
    );

    // The cycle after a load the timer still reflects the old rest_time.
    assign w_phase_end = (r_state == RUN) && !r_load_skip && (tmr.next_time == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OFF: begin
                if (w_power_edge) w_state_next = IDLE;
            end
            IDLE: begin
                if (w_power_edge)      w_state_next = OFF;
                else if (w_start_edge) w_state_next = RUN;
            end
            RUN: begin
                if (w_power_edge)                          w_state_next = OFF;
                else if (w_phase_end && r_phase == PH_SPIN) w_state_next = DONE;
                else if (w_pause_edge)                     w_state_next = PAUSE;
            end
            PAUSE: begin
                if (w_power_edge)      w_state_next = OFF;
                else if (w_pause_edge) w_state_next = RUN;
            end
            DONE: begin
                if (w_power_edge)                   w_state_next = OFF;
                else if (r_buzz_cnt == c_buzz_last) w_state_next = IDLE;
            end
            default: w_state_next = OFF;
        endcase
    end

    always_comb begin
        w_off_r   = 1'b0;
        w_stop    = 1'b1;
        w_dis     = 1'b0;
        w_running = 1'b0;
        w_buzzer  = 1'b0;
        case (r_state)
            OFF:  w_off_r = 1'b1;
            IDLE: w_dis   = 1'b1;
            RUN: begin
                w_stop    = 1'b0;
                w_running = 1'b1;
            end
            DONE: begin
                w_dis    = 1'b1;
                w_buzzer = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rest_time <= '0;
            r_phase     <= PH_NONE;
            r_load_skip <= 1'b0;
            r_buzz_cnt  <= '0;
        end else begin
            r_buzz_cnt <= (r_state == DONE && w_state_next == DONE) ?
                          r_buzz_cnt + 1'b1 : '0;
            if (w_power_edge && r_state != OFF) begin
                r_rest_time <= '0;
                r_phase     <= PH_NONE;
                r_load_skip <= 1'b0;
            end else begin
                case (r_state)
                    OFF: begin
                        if (w_power_edge) begin
                            r_rest_time <= c_wash_t;
                            r_phase     <= PH_WASH;
                            r_load_skip <= 1'b0;
                        end
                    end
                    IDLE: begin
                        r_rest_time <= c_wash_t;
                        r_phase     <= PH_WASH;
                        r_load_skip <= w_start_edge;
                    end
                    RUN: begin
                        if (r_load_skip) begin
                            r_load_skip <= 1'b0;
                        end else if (w_phase_end) begin
                            case (r_phase)
                                PH_WASH: begin
                                    r_phase     <= PH_RINSE;
                                    r_rest_time <= c_rinse_t;
                                    r_load_skip <= 1'b1;
                                end
                                PH_RINSE: begin
                                    r_phase     <= PH_SPIN;
                                    r_rest_time <= c_spin_t;
                                    r_load_skip <= 1'b1;
                                end
                                default: begin
                                    r_phase     <= PH_NONE;
                                    r_rest_time <= '0;
                                end
                            endcase
                        end else begin
                            r_rest_time <= tmr.next_time;
                        end
                    end
                    PAUSE: begin
                        if (w_pause_edge) r_load_skip <= 1'b1;
                    end
                    DONE: begin
                        if (w_state_next == IDLE) begin
                            r_rest_time <= c_wash_t;
                            r_phase     <= PH_WASH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tmr.rest_time = r_rest_time;
    assign tmr.stop      = w_stop;
    assign tmr.dis       = w_dis;
    assign tmr.off_r     = w_off_r;
    assign phase         = r_phase;
    assign running       = w_running;
    assign buzzer        = w_buzzer;

endmodule

`default_nettype wire

// File: tb/tb_wash_sequencer.sv
// ============================================================================
// Module      : tb_wash_sequencer
// Description : Directed bench for wash_sequencer with a cycle=6 timer model
//               closing the rest_time/next_time loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_sequencer;
    import wash_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power_btn = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic [1:0] phase;
    logic       running;
    logic       buzzer;
    logic [2:0] t_cnt;

    int n_checks = 0;
    int n_errors = 0;

    wash_sequencer_if tif ();

    wash_sequencer #(
        .WASH_T   (9),
        .RINSE_T  (6),
        .SPIN_T   (6),
        .BUZZ_CYC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .power_btn (power_btn),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .tmr       (tif),
        .phase     (phase),
        .running   (running),
        .buzzer    (buzzer)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] sat_dec(input logic [6:0] v);
        return (v == 7'd0) ? 7'd0 : v - 7'd1;
    endfunction

    // Timer model: one decrement every 6 cycles, applied on two consecutive
    // cycles so both values circulating in the two-register loop step down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tif.next_time <= 7'd0;
            t_cnt         <= 3'd0;
        end else if (tif.off_r) begin
            tif.next_time <= 7'd0;
            t_cnt         <= 3'd0;
        end else if (tif.dis || tif.stop) begin
            tif.next_time <= tif.dis ? 7'(TOTAL_T) : tif.rest_time;
            t_cnt         <= 3'd0;
        end else begin
            tif.next_time <= (t_cnt >= 3'd4) ? sat_dec(tif.rest_time) : tif.rest_time;
            t_cnt         <= (t_cnt == 3'd5) ? 3'd0 : t_cnt + 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mask: bit0 power, bit1 start, bit2 pause
    task automatic press(input logic [2:0] mask);
        power_btn = mask[0];
        start_btn = mask[1];
        pause_btn = mask[2];
        tick();
        power_btn = 1'b0;
        start_btn = 1'b0;
        pause_btn = 1'b0;
    endtask

    task automatic wait_change(input string tag);
        logic [6:0] old;
        logic       seen;
        old  = tif.rest_time;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (tif.rest_time != old) seen = 1'b1;
        end
        chk({tag, "_changed"}, seen, 1);
    endtask

    task automatic count_down(input string tag, input int from, input int to, input int ph);
        for (int v = from; v >= to; v--) begin
            wait_change(tag);
            chk({tag, "_rest"}, tif.rest_time, v);
        end
        chk({tag, "_phase"}, phase, ph);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_off_r"},   tif.off_r, 1);
        chk({tag, "_stop"},    tif.stop, 1);
        chk({tag, "_dis"},     tif.dis, 0);
        chk({tag, "_rest"},    tif.rest_time, 0);
        chk({tag, "_phase"},   phase, 3);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_buzzer"},  buzzer, 0);
    endtask

    initial begin
        int  nbuzz;
        logic hold_bad;

        repeat (2) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk("off_after_rst", tif.off_r, 1);

        // 1: power on
        press(3'b001);
        chk("idle_off_r", tif.off_r, 0);
        chk("idle_dis",   tif.dis, 1);
        chk("idle_stop",  tif.stop, 1);
        chk("idle_rest",  tif.rest_time, 9);
        chk("idle_phase", phase, 0);

        // 2: full program
        press(3'b010);
        chk("run_running", running, 1);
        chk("run_stop",    tif.stop, 0);
        chk("run_dis",     tif.dis, 0);
        chk("run_rest",    tif.rest_time, 9);
        count_down("wash", 8, 1, 0);
        count_down("rinse_ld", 6, 6, 1);
        count_down("rinse", 5, 1, 1);
        count_down("spin_ld", 6, 6, 2);
        count_down("spin", 5, 1, 2);
        wait_change("done");
        chk("done_rest",    tif.rest_time, 0);
        chk("done_phase",   phase, 3);
        chk("done_running", running, 0);
        chk("done_dis",     tif.dis, 1);
        nbuzz = 0;
        for (int i = 0; i < 20 && buzzer; i++) begin
            nbuzz++;
            tick();
        end
        chk("buzz_cycles", nbuzz, 8);
        chk("ret_idle_dis",   tif.dis, 1);
        chk("ret_idle_rest",  tif.rest_time, 9);
        chk("ret_idle_phase", phase, 0);

        // 3: pause in RINSE at rest_time=5
        press(3'b010);
        count_down("wash2", 8, 1, 0);
        count_down("rinse2_ld", 6, 6, 1);
        count_down("rinse2", 5, 5, 1);
        press(3'b100);
        chk("pause_stop",    tif.stop, 1);
        chk("pause_running", running, 0);
        chk("pause_rest",    tif.rest_time, 5);
        hold_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tif.rest_time != 7'd5 || !tif.stop) hold_bad = 1'b1;
        end
        chk("pause_hold", hold_bad, 0);
        press(3'b100);
        chk("resume_running", running, 1);
        chk("resume_rest",    tif.rest_time, 5);
        count_down("resume", 4, 1, 1);
        count_down("spin2_ld", 6, 6, 2);
        count_down("spin2", 5, 3, 2);

        // 4: power off during SPIN at rest_time=3
        press(3'b001);
        chk("pwroff_off_r", tif.off_r, 1);
        chk("pwroff_rest",  tif.rest_time, 0);
        chk("pwroff_phase", phase, 3);
        press(3'b010);
        tick();
        press(3'b010);
        repeat (3) tick();
        chk("off_start_off_r",   tif.off_r, 1);
        chk("off_start_running", running, 0);
        chk("off_start_dis",     tif.dis, 0);

        // 5: simultaneous edges in RUN
        press(3'b001);
        press(3'b010);
        repeat (3) tick();
        chk("pre_all_running", running, 1);
        press(3'b111);
        chk("all_off_r",   tif.off_r, 1);
        chk("all_running", running, 0);
        chk("all_phase",   phase, 3);
        repeat (3) tick();
        chk("all_still_off", tif.off_r, 1);

        // 6: async reset mid-WASH at rest_time=4
        press(3'b001);
        press(3'b010);
        count_down("wash3", 8, 4, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_off_r", tif.off_r, 1);
        chk("post_rst_phase", phase, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
